// File: rtl/noc_async_fifo_wr.sv
// Write-side end of the NoC async FIFO link: owns the packet storage and the
// Gray write pointer, accepts packets from a local valid/ready source and
// exposes storage plus pointer to a reader running in a foreign clock domain.
//
// Ports:
//   clk_i, reset_i  write-domain clock, synchronous active-high reset
//   wr_data_i       packet to enqueue
//   wr_valid_i      wr_data_i valid
//   wr_ready_o      FIFO can accept (registered)
//   fifo_data_o     storage entry addressed by fifo_raddr_i (combinational)
//   fifo_raddr_i    Gray read pointer from the reader domain (asynchronous)
//   fifo_waddr_o    Gray write pointer to the reader domain (registered)
//   full_o          FIFO full, pessimistic (registered)
//   fill_o          occupancy estimate 0..2**AWIDTH (registered)
module noc_async_fifo_wr #(
  parameter int unsigned PACKET_SIZE = 160,
  parameter int unsigned AWIDTH      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PACKET_SIZE-1:0] wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [PACKET_SIZE-1:0] fifo_data_o,
  input  logic [AWIDTH:0]        fifo_raddr_i,
  output logic [AWIDTH:0]        fifo_waddr_o,
  output logic                   full_o,
  output logic [AWIDTH:0]        fill_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned PW    = AWIDTH + 1;
  // Full when the write pointer equals the read pointer with its two top Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (AWIDTH - 1);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PACKET_SIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]          rsync_q [SYNC_STAGES];

  logic [PW-1:0]     wptr_bin_q, wptr_bin_d;
  logic [PW-1:0]     waddr_q, waddr_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              accept_c;
  logic [PW-1:0]     rptr_sync_gray_c;
  logic [PW-1:0]     rptr_sync_bin_c;
  logic [AWIDTH-1:0] rd_idx_c;

  assign rptr_sync_gray_c = rsync_q[SYNC_STAGES-1];

  // Next-state pointer, full and fill; full/fill look at the post-accept pointer
  // so full_o asserts right after the filling write and no overrun can happen.
  always_comb begin
    accept_c        = wr_valid_i & ready_q;
    wptr_bin_d      = wptr_bin_q;
    if (accept_c) begin
      wptr_bin_d = wptr_bin_q + PW'(1);
    end
    waddr_d         = bin2gray(wptr_bin_d);
    rptr_sync_bin_c = gray2bin(rptr_sync_gray_c);
    full_d          = (waddr_d == (rptr_sync_gray_c ^ FULL_MASK));
    ready_d         = ~full_d;
    fill_d          = wptr_bin_d - rptr_sync_bin_c;
  end

  // Pointer/status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_bin_q <= '0;
      waddr_q    <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      wptr_bin_q <= wptr_bin_d;
      waddr_q    <= waddr_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
    end
  end

  // Read-pointer synchronizer into clk_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        rsync_q[i] <= '0;
      end
    end else begin
      rsync_q[0] <= fifo_raddr_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        rsync_q[i] <= rsync_q[i-1];
      end
    end
  end

  // Storage, not reset; written on the same edge that advances the pointer.
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      mem_q[wptr_bin_q[AWIDTH-1:0]] <= wr_data_i;
    end
  end

  // Reader-side data lookup; slot index is the low bits of the binary read pointer.
  assign rd_idx_c    = AWIDTH'(gray2bin(fifo_raddr_i));
  assign fifo_data_o = mem_q[rd_idx_c];

  assign fifo_waddr_o = waddr_q;
  assign full_o       = full_q;
  assign wr_ready_o   = ready_q;
  assign fill_o       = fill_q;

endmodule

// File: tb/tb_noc_async_fifo_wr.sv
// Bench for noc_async_fifo_wr: directed pointer/full/fill checks plus a model
// reader in an unrelated clock draining a 40-packet stream.
module tb_noc_async_fifo_wr;

  localparam int unsigned PS = 160;
  localparam int unsigned AW = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned PW = AW + 1;

  typedef logic [PS-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          rclk = 1'b0;
  logic          reset;
  pkt_t          wr_data;
  logic          wr_valid;
  logic          wr_ready;
  pkt_t          fifo_data;
  logic [PW-1:0] fifo_raddr;
  logic [PW-1:0] fifo_waddr;
  logic          full;
  logic [PW-1:0] fill;

  int n_vec  = 0;
  int n_miss = 0;

  pkt_t sb[$];

  bit            rd_en = 1'b0;
  logic [PW-1:0] raddr_man = '0;
  logic [PW-1:0] m_rptr = '0;
  logic [PW-1:0] m_ws1 = '0;
  logic [PW-1:0] m_ws2 = '0;
  int            rcv_cnt = 0;
  pkt_t          rd_exp;

  noc_async_fifo_wr #(.PACKET_SIZE(PS), .AWIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .fifo_data_o (fifo_data),
    .fifo_raddr_i(fifo_raddr),
    .fifo_waddr_o(fifo_waddr),
    .full_o      (full),
    .fill_o      (fill)
  );

  always #50 clk = ~clk;
  initial forever begin
    #68 rclk = 1'b1;
    #69 rclk = 1'b0;
  end

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign fifo_raddr = rd_en ? gray(m_rptr) : raddr_man;

  task automatic chk(input string tag, input pkt_t got, input pkt_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model reader: syncs the write pointer into rclk and pops whenever non-empty.
  always @(posedge rclk) begin
    if (!rd_en) begin
      m_rptr  <= '0;
      m_ws1   <= '0;
      m_ws2   <= '0;
      rcv_cnt <= 0;
    end else begin
      m_ws1 <= fifo_waddr;
      m_ws2 <= m_ws1;
      if (gray(m_rptr) != m_ws2) begin
        if (sb.size() != 0) rd_exp = sb.pop_front();
        else                rd_exp = 'x;
        chk("stream_data", fifo_data, rd_exp);
        m_rptr  <= m_rptr + PW'(1);
        rcv_cnt <= rcv_cnt + 1;
      end
    end
  end

  // Starts and ends at a negedge; leaves wr_valid high for back-to-back use.
  task automatic wr_push(input pkt_t d);
    int w;
    w        = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && w < 200) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    if (!wr_ready) begin
      chk("wr_accept_timeout", PS'(wr_ready), PS'(1));
      wr_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(d);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  pkt_t r;
  int   cnt;

  initial begin
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_waddr", PS'(fifo_waddr), PS'(0));
    chk("rst_fill",  PS'(fill),       PS'(0));
    chk("rst_full",  PS'(full),       PS'(0));
    chk("rst_ready", PS'(wr_ready),   PS'(1));

    // Three writes, reader parked at 0
    wr_push(PS'(32'hA)); chk("t1_waddr1", PS'(fifo_waddr), PS'(4'd1));
    wr_push(PS'(32'hB)); chk("t1_waddr2", PS'(fifo_waddr), PS'(4'd3));
    wr_push(PS'(32'hC)); chk("t1_waddr3", PS'(fifo_waddr), PS'(4'd2));
    wr_valid = 1'b0;
    chk("t1_fill", PS'(fill), PS'(3));
    chk("t1_full", PS'(full), PS'(0));
    chk("t1_data", fifo_data, PS'(32'hA));

    // Fill to eight entries, then hold a ninth valid
    do_reset();
    for (int i = 0; i < 8; i++) wr_push(PS'(32'h100 + i));
    chk("full_full",  PS'(full),       PS'(1));
    chk("full_ready", PS'(wr_ready),   PS'(0));
    chk("full_waddr", PS'(fifo_waddr), PS'(4'b1100));
    chk("full_fill",  PS'(fill),       PS'(8));
    wr_data = PS'(32'h1FF);
    cycles(3);
    chk("full_hold_waddr", PS'(fifo_waddr), PS'(4'b1100));
    chk("full_hold_fill",  PS'(fill),       PS'(8));
    chk("full_hold_slot0", fifo_data,       PS'(32'h100));

    // One pop: ready returns after SS+1 edges, held ninth packet lands in slot 0
    raddr_man = PW'(1);
    cnt = 0;
    while (!wr_ready && cnt < 20) begin
      cycles(1);
      cnt++;
    end
    chk("pop_latency", PS'(cnt),  PS'(SS + 1));
    chk("pop_fill",    PS'(fill), PS'(7));
    cycles(1);
    wr_valid = 1'b0;
    chk("pop_wr_waddr", PS'(fifo_waddr), PS'(4'b1101));
    chk("pop_wr_full",  PS'(full),       PS'(1));
    raddr_man = 4'b1100;
    #1;
    chk("pop_wr_slot0", fifo_data, PS'(32'h1FF));

    // Combinational read path across all slots
    raddr_man = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      wr_push(r);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_man = gray(PW'(i));
      #1;
      if (sb.size() != 0) r = sb.pop_front();
      else                r = 'x;
      chk("dp_data", fifo_data, r);
    end

    // 40-packet stream against the model reader
    raddr_man = '0;
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        cycles($urandom_range(1, 3));
      end
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      wr_push(r);
    end
    wr_valid = 1'b0;
    cnt = 0;
    while (rcv_cnt < 40 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("stream_count", PS'(rcv_cnt), PS'(40));
    cycles(SS + 3);
    chk("stream_fill",  PS'(fill),       PS'(0));
    chk("stream_full",  PS'(full),       PS'(0));
    chk("stream_waddr", PS'(fifo_waddr), PS'(4'b1100));
    chk("stream_sb",    PS'(sb.size()),  PS'(0));

    // Reset with five entries queued
    rd_en     = 1'b0;
    raddr_man = '0;
    do_reset();
    for (int i = 0; i < 5; i++) wr_push(PS'(32'h500 + i));
    wr_valid = 1'b0;
    chk("q5_fill", PS'(fill), PS'(5));
    do_reset();
    chk("q5_rst_waddr", PS'(fifo_waddr), PS'(0));
    chk("q5_rst_fill",  PS'(fill),       PS'(0));
    chk("q5_rst_ready", PS'(wr_ready),   PS'(1));
    chk("q5_rst_full",  PS'(full),       PS'(0));
    wr_push(PS'(32'hDEAD));
    wr_valid = 1'b0;
    chk("q5_new_waddr", PS'(fifo_waddr), PS'(4'd1));
    chk("q5_new_slot0", fifo_data,       PS'(32'hDEAD));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
